ir_nec_tx_queue: RTL

Parametrised NEC-family infrared transmitter with a command FIFO, extended-address mode, automatic repeat codes and a configurable carrier. Software or keypad logic pushes address/command words, and the block serialises them onto the IR LED pin at the protocol's fixed 108 ms frame cadence. It is the successor to the single-shot NEC transmitter on the DE1-SoC IR path and sits between the control logic and the IRDA TX pin.

---
 rtl/ir_nec_tx_queue.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ir_nec_tx_queue.sv
// Queued NEC / extended-NEC infrared transmitter: FIFO of address/command words,
// fixed frame cadence, automatic repeat codes and a free-running modulation carrier.
module ir_nec_tx_queue #(
    parameter int UNIT_CYC       = 28125,
    parameter int FRAME_UNITS    = 192,
    parameter int CARRIER_PERIOD = 1316,
    parameter int CARRIER_HIGH   = 439,
    parameter bit MODULATE       = 1'b1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        iCLK_50,
    input  logic        iRST_n,
    input  logic        iWR,
    input  logic [15:0] iADDRESS,
    input  logic [7:0]  iCOMMAND,
    input  logic        iEXT,
    input  logic        iREPEAT,
    output logic        oFULL,
    output logic        oOVF,
    output logic        oIR_TX_BUSY,
    output logic        oIRDA_ENV,
    output logic        oIRDA
);
    localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int CW = (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;
    localparam int FW = ($clog2(FRAME_UNITS + 1) > 8) ? $clog2(FRAME_UNITS + 1) : 8;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [UW-1:0] UNIT_LAST  = UW'(UNIT_CYC - 1);
    localparam logic [CW-1:0] CAR_LAST   = CW'(CARRIER_PERIOD - 1);
    localparam logic [CW-1:0] CAR_HIGH   = CW'(CARRIER_HIGH);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_UNITS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LEAD_H, S_LEAD_L, S_BIT_H, S_BIT_L, S_STOP,
        S_REP_H, S_REP_L, S_REP_STOP, S_GAP
    } state_t;

    state_t          r_state;
    logic            r_env, r_busy, r_last_vld, r_ovf;
    logic [31:0]     r_sh;
    logic [4:0]      r_bit_cnt, r_seg_cnt;
    logic [UW-1:0]   r_unit_cnt;
    logic [FW-1:0]   r_frm_cnt;
    logic [CW-1:0]   r_car_cnt;
    logic [24:0]     r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr, r_rd_ptr;

    logic            w_empty, w_full, w_pop, w_push, w_start_rep;
    logic            w_tick, w_seg_done, w_frame_end, w_car;
    logic [4:0]      w_seg_len;
    logic [24:0]     w_head;
    logic [31:0]     w_payload;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_tick      = r_busy && (r_unit_cnt == UNIT_LAST);
    assign w_frame_end = w_tick && (r_frm_cnt == FRAME_LAST);
    assign w_seg_done  = w_tick && (r_seg_cnt == w_seg_len - 5'd1);

    // A new frame always wins over a repeat at the end of a frame period.
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || (r_state == S_GAP && w_frame_end));
    assign w_start_rep = (r_state == S_GAP) && w_frame_end && w_empty && iREPEAT && r_last_vld;
    assign w_push      = iWR && (!w_full || w_pop);

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_payload = {~w_head[7:0], w_head[7:0],
                        (w_head[24] ? w_head[23:16] : ~w_head[15:8]), w_head[15:8]};

    always_comb begin
        w_seg_len = 5'd1;
        case (r_state)
            S_LEAD_H, S_REP_H: w_seg_len = 5'd16;
            S_LEAD_L:          w_seg_len = 5'd8;
            S_REP_L:           w_seg_len = 5'd4;
            S_BIT_L:           w_seg_len = r_sh[0] ? 5'd3 : 5'd1;
            default:           w_seg_len = 5'd1;
        endcase
    end

    always_ff @(posedge iCLK_50) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= {iEXT, iADDRESS, iCOMMAND};
    end

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_ovf <= iWR && w_full && !w_pop;
        end
    end

    // Carrier runs freely from reset; the frame machine never touches its phase.
    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n)
            r_car_cnt <= '0;
        else
            r_car_cnt <= (r_car_cnt == CAR_LAST) ? '0 : r_car_cnt + 1'b1;
    end
    assign w_car = (r_car_cnt < CAR_HIGH);

    always_ff @(posedge iCLK_50 or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state    <= S_IDLE;
            r_env      <= 1'b0;
            r_busy     <= 1'b0;
            r_last_vld <= 1'b0;
            r_sh       <= '0;
            r_bit_cnt  <= '0;
            r_unit_cnt <= '0;
            r_seg_cnt  <= '0;
            r_frm_cnt  <= '0;
        end else if (w_pop || w_start_rep) begin
            r_state    <= w_pop ? S_LEAD_H : S_REP_H;
            r_env      <= 1'b1;
            r_busy     <= 1'b1;
            r_unit_cnt <= '0;
            r_seg_cnt  <= '0;
            r_frm_cnt  <= '0;
            if (w_pop) begin
                r_sh       <= w_payload;
                r_bit_cnt  <= '0;
                r_last_vld <= 1'b1;
            end
        end else if (r_busy) begin
            r_unit_cnt <= w_tick ? '0 : r_unit_cnt + 1'b1;
            if (w_tick)
                r_frm_cnt <= r_frm_cnt + 1'b1;
            if (w_seg_done)
                r_seg_cnt <= '0;
            else if (w_tick)
                r_seg_cnt <= r_seg_cnt + 1'b1;
            if (w_seg_done) begin
                case (r_state)
                    S_LEAD_H:   begin r_state <= S_LEAD_L;   r_env <= 1'b0; end
                    S_LEAD_L:   begin r_state <= S_BIT_H;    r_env <= 1'b1; end
                    S_BIT_H:    begin r_state <= S_BIT_L;    r_env <= 1'b0; end
                    S_BIT_L: begin
                        r_sh      <= r_sh >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        r_env     <= 1'b1;
                        r_state   <= (r_bit_cnt == 5'd31) ? S_STOP : S_BIT_H;
                    end
                    S_STOP:     begin r_state <= S_GAP;      r_env <= 1'b0; end
                    S_REP_H:    begin r_state <= S_REP_L;    r_env <= 1'b0; end
                    S_REP_L:    begin r_state <= S_REP_STOP; r_env <= 1'b1; end
                    S_REP_STOP: begin r_state <= S_GAP;      r_env <= 1'b0; end
                    S_GAP: begin
                        if (w_frame_end) begin
                            r_state <= S_IDLE;
                            r_env   <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign oFULL       = w_full;
    assign oOVF        = r_ovf;
    assign oIR_TX_BUSY = r_busy;
    assign oIRDA_ENV   = r_env;
    assign oIRDA       = MODULATE ? (r_env & w_car) : r_env;

endmodule
